// File: rtl/fp_conv_pkg.sv
// Shared definitions for the float converter: word widths and the packer state encoding.
`default_nettype none

package fp_conv_pkg;

   localparam int FP_W     = 32;
   localparam int FP_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FRAC = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/frac_div_step.sv
// One restoring-division step: doubles the remainder and subtracts den when it fits.
`default_nettype none

module frac_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] den,
   output logic         div_bit,
   output logic [W-1:0] next_rem
);

   logic [W:0] rem2;

   assign rem2     = {rem, 1'b0};
   assign div_bit  = (rem2 >= {1'b0, den});
   // rem < den guarantees the difference fits back into W bits
   assign next_rem = div_bit ? W'(rem2 - {1'b0, den}) : rem2[W-1:0];

endmodule

`default_nettype wire

// File: rtl/fixed_point_packer.sv
// Packs sign, integer part and num/den fraction into an MSB-aligned fixed-point word plus
// integer bit count, one bit per cycle for both the alignment scan and the division.
`default_nettype none

module fixed_point_packer
   import fp_conv_pkg::*;
#(
   parameter int W     = FP_W,
   parameter int CNT_W = FP_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [W-1:0]     int_part,
   input  logic [W-1:0]     frac_num,
   input  logic [W-1:0]     frac_den,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [W-1:0]     out_word,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_err
);

   localparam int PTR_W = $clog2(W);

   state_t             state;
   state_t             state_nx;
   logic [W-1:0]       sh;
   logic [W-1:0]       rem;
   logic [W-1:0]       den_r;
   logic               err_r;
   logic               sign_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [PTR_W-1:0]   k;
   logic [PTR_W-1:0]   ptr;
   logic               div_bit;
   logic               frac_bit;
   logic [W-1:0]       next_rem;

   frac_div_step #(.W(W)) u_div (
      .rem      (rem),
      .den      (den_r),
      .div_bit  (div_bit),
      .next_rem (next_rem)
   );

   // An invalid fraction still walks every bit position, it just emits zeros
   assign frac_bit  = div_bit & ~err_r;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (in_valid) state_nx = (int_part == '0) ? FRAC : SCAN;
         SCAN: if (sh[W-1])  state_nx = (k == '0) ? DONE : FRAC;
         FRAC: if (ptr == '0) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh       <= '0;
         rem      <= '0;
         den_r    <= '0;
         err_r    <= 1'b0;
         sign_r   <= 1'b0;
         cnt_r    <= '0;
         k        <= '0;
         ptr      <= '0;
         out_sign <= 1'b0;
         out_word <= '0;
         out_cnt  <= '0;
         out_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sh     <= int_part;
               rem    <= frac_num;
               den_r  <= frac_den;
               err_r  <= (frac_den == '0) || (frac_num >= frac_den);
               sign_r <= in_sign;
               cnt_r  <= '0;
               k      <= '0;
               ptr    <= PTR_W'(W - 1);
            end
            SCAN: begin
               if (sh[W-1]) begin
                  cnt_r <= CNT_W'(W) - CNT_W'(k);
                  ptr   <= k - PTR_W'(1);
                  // Integer fills the whole word: no fraction bits to compute
                  if (k == '0) begin
                     out_sign <= sign_r;
                     out_word <= sh;
                     out_cnt  <= CNT_W'(W);
                     out_err  <= err_r;
                  end
               end else begin
                  sh <= sh << 1;
                  k  <= k + PTR_W'(1);
               end
            end
            FRAC: begin
               sh[ptr] <= frac_bit;
               rem     <= next_rem;
               ptr     <= ptr - PTR_W'(1);
               if (ptr == '0) begin
                  out_sign <= sign_r;
                  out_word <= {sh[W-1:1], frac_bit};
                  out_cnt  <= cnt_r;
                  out_err  <= err_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_packer.sv
// Self-checking bench for fixed_point_packer against an arithmetic reference model.
`default_nettype none

module tb_fixed_point_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [31:0] int_part;
   logic [31:0] frac_num;
   logic [31:0] frac_den;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [31:0] out_word;
   logic [7:0]  out_cnt;
   logic        out_err;

   int tests = 0;
   int fails = 0;

   fixed_point_packer #(.W(32), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .int_part  (int_part),
      .frac_num  (frac_num),
      .frac_den  (frac_den),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_word  (out_word),
      .out_cnt   (out_cnt),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Reference: word = int * 2^(32-cnt) + floor(num * 2^(32-cnt) / den)
   function automatic void model(input logic [31:0] i, input logic [31:0] n, input logic [31:0] d,
                                 output logic [31:0] w, output logic [7:0] c,
                                 output logic e, output int lat);
      logic [63:0] v;
      logic [63:0] f;
      int len;
      len = 0;
      v = {32'd0, i};
      while (v != 0) begin
         v = v >> 1;
         len++;
      end
      c = 8'(len);
      e = (d == 0) || (n >= d);
      if (e || len == 32) f = 0;
      else                f = ({32'd0, n} << (32 - len)) / {32'd0, d};
      w = 32'((({32'd0, i}) << (32 - len)) | f);
      lat = (i == 0) ? 32 : 2 * (32 - len) + 1;
   endfunction

   // Accepts one request and counts posedges until out_valid (bounded)
   task automatic drive_req(input logic s, input logic [31:0] i, input logic [31:0] n,
                            input logic [31:0] d, input bit busy_noise, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = s;
      int_part = i;
      frac_num = n;
      frac_den = d;
      @(posedge clk);
      #1;
      in_valid = busy_noise;
      in_sign  = 1'($urandom);
      int_part = $urandom;
      frac_num = $urandom;
      frac_den = $urandom;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({in_ready, out_valid, out_sign, out_word, out_cnt, out_err} !== {1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: rdy=%0b vld=%0b sign=%0b word=%h cnt=%0d err=%0b, expected rdy=1 others 0",
                  in_ready, out_valid, out_sign, out_word, out_cnt, out_err);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] vi [6] = '{32'd5, 32'd0, 32'h8000_0000, 32'd3, 32'd3, 32'd1};
      logic [31:0] vn [6] = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd7, 32'd3};
      logic [31:0] vd [6] = '{32'd4, 32'd3, 32'd1, 32'd0, 32'd7, 32'd7};
      logic [31:0] ew [6] = '{32'hA800_0000, 32'h5555_5555, 32'h8000_0000, 32'hC000_0000, 32'hC000_0000, 32'h8000_0000};
      logic [7:0]  ec [6] = '{8'd3, 8'd0, 8'd32, 8'd2, 8'd2, 8'd1};
      bit          ee [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int          el [6] = '{59, 32, 1, 61, 61, 63};
      int lat;
      logic [31:0] mw; logic [7:0] mc; logic me; int ml;
      for (int t = 0; t < 6; t++) begin
         logic sgn;
         sgn = (t == 0) ? 1'b1 : 1'(t[1]);
         drive_req(sgn, vi[t], vn[t], vd[t], 1'b0, lat);
         model(vi[t], vn[t], vd[t], mw, mc, me, ml);
         // Last vector: 1 + 3/7 = 1.0110110..., word 0x80000000 | (3<<31)/7
         if (t == 5) ew[t] = mw;
         tests++;
         if (lat !== el[t] || out_word !== ew[t] || out_cnt !== ec[t] || out_err !== ee[t] || out_sign !== sgn) begin
            fails++;
            $display("FAIL directed_%0d: lat=%0d word=%h cnt=%0d err=%0b sign=%0b, expected lat=%0d word=%h cnt=%0d err=%0b sign=%0b",
                     t, lat, out_word, out_cnt, out_err, out_sign, el[t], ew[t], ec[t], ee[t], sgn);
         end
         release_out();
      end
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] i, n, d, mw;
      logic [7:0] mc;
      logic me, s;
      int ml;
      for (int t = 0; t < 24; t++) begin
         s = 1'($urandom);
         i = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (d == 0) d = 1;
         case ($urandom_range(0, 7))
            0:       n = d;
            1:       begin d = 0; n = $urandom; end
            default: n = $urandom % d;
         endcase
         model(i, n, d, mw, mc, me, ml);
         drive_req(s, i, n, d, 1'b0, lat);
         tests++;
         if (lat !== ml || out_word !== mw || out_cnt !== mc || out_err !== me || out_sign !== s) begin
            fails++;
            $display("FAIL random_%0d (i=%h n=%h d=%h): lat=%0d word=%h cnt=%0d err=%0b sign=%0b, expected lat=%0d word=%h cnt=%0d err=%0b sign=%0b",
                     t, i, n, d, lat, out_word, out_cnt, out_err, out_sign, ml, mw, mc, me, s);
         end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit bad;
      logic [31:0] w0;
      drive_req(1'b1, 32'd5, 32'd1, 32'd4, 1'b0, lat);
      w0 = out_word;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (!out_valid || in_ready || out_word !== 32'hA800_0000 || out_cnt !== 8'd3 || out_sign !== 1'b1) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL hold_in_done: vld=%0b rdy=%0b word=%h cnt=%0d, expected vld=1 rdy=0 word=a8000000 cnt=3",
                  out_valid, in_ready, out_word, out_cnt);
      end
      release_out();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_word !== w0) begin
         fails++;
         $display("FAIL release_to_idle: vld=%0b rdy=%0b word=%h, expected vld=0 rdy=1 word=%h",
                  out_valid, in_ready, out_word, w0);
      end
   endtask

   task automatic test_busy_ignored();
      int lat;
      logic [31:0] mw; logic [7:0] mc; logic me; int ml;
      model(32'd12, 32'd2, 32'd5, mw, mc, me, ml);
      drive_req(1'b0, 32'd12, 32'd2, 32'd5, 1'b1, lat);
      tests++;
      if (lat !== ml || out_word !== mw || out_cnt !== mc || out_err !== me || out_sign !== 1'b0) begin
         fails++;
         $display("FAIL busy_ignored: lat=%0d word=%h cnt=%0d err=%0b, expected lat=%0d word=%h cnt=%0d err=%0b",
                  lat, out_word, out_cnt, out_err, ml, mw, mc, me);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = 1'b1;
      int_part = 32'd0;
      frac_num = 32'd1;
      frac_den = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if ({in_ready, out_valid, out_sign, out_word, out_cnt, out_err} !== {1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_mid_frac: rdy=%0b vld=%0b sign=%0b word=%h cnt=%0d err=%0b, expected rdy=1 others 0",
                  in_ready, out_valid, out_sign, out_word, out_cnt, out_err);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_discard: vld=%0b rdy=%0b, expected vld=0 rdy=1", out_valid, in_ready);
      end
      drive_req(1'b0, 32'd0, 32'd1, 32'd3, 1'b0, lat);
      tests++;
      if (lat !== 32 || out_word !== 32'h5555_5555 || out_cnt !== 8'd0 || out_err !== 1'b0) begin
         fails++;
         $display("FAIL after_reset: lat=%0d word=%h cnt=%0d err=%0b, expected lat=32 word=55555555 cnt=0 err=0",
                  lat, out_word, out_cnt, out_err);
      end
      release_out();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      int_part  = '0;
      frac_num  = '0;
      frac_den  = '0;
      out_ready = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_busy_ignored();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
